// File: rtl/score_combo_engine.sv
// score_combo_engine
//   Collects hit judgements from NUM_LANES judge lanes, holds one pending
//   judgement per lane, serialises them with a round-robin arbiter, and
//   updates combo / max combo / multiplier (stage 1) and a saturating
//   score (stage 2).
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, stop           game control (start from IDLE/DONE, stop in PLAY)
//   hit_valid, hit_grade  per-lane judgement strobe and 2-bit grade
//   score, combo, max_combo, multiplier   game counters
//   state                 0=IDLE 1=PLAY 2=DRAIN 3=DONE
//   busy                  judgements still pending or in flight
//   saturated, overrun    sticky flags for score clamp / dropped hit
module score_combo_engine #(
  parameter int NUM_LANES   = 4,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 8,
  parameter int PTS_GOOD    = 32,
  parameter int PTS_PERFECT = 256,
  parameter int COMBO_STEP  = 16,
  parameter int MULT_MAX    = 17
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NUM_LANES-1:0]   hit_valid,
  input  logic [2*NUM_LANES-1:0] hit_grade,
  output logic [SCORE_W-1:0]     score,
  output logic [COMBO_W-1:0]     combo,
  output logic [COMBO_W-1:0]     max_combo,
  output logic [4:0]             multiplier,
  output logic [1:0]             state,
  output logic                   busy,
  output logic                   saturated,
  output logic                   overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int LW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PTS_MAX = (PTS_PERFECT > PTS_GOOD) ? PTS_PERFECT : PTS_GOOD;
  localparam int PROD_W  = $clog2(PTS_MAX * MULT_MAX + 1);
  // Wide enough that neither operand is truncated before the clamp test.
  localparam int SUM_W   = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;

  logic [1:0]                  state_q, state_d;
  logic [NUM_LANES-1:0]        pending_q, pending_d;
  logic [NUM_LANES-1:0][1:0]   grade_q, grade_d;
  logic [LW-1:0]               ptr_q, ptr_d;
  logic [COMBO_W-1:0]          combo_q, combo_d;
  logic [COMBO_W-1:0]          max_combo_q, max_combo_d;
  logic [4:0]                  mult_q, mult_d;
  logic                        s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0]           prod_q, prod_d;
  logic [SCORE_W-1:0]          score_q, score_d;
  logic                        sat_q, sat_d;
  logic                        overrun_q, overrun_d;

  logic [NUM_LANES-1:0][1:0]   hg_s;
  logic                        gnt_valid_s;
  logic [LW-1:0]               gnt_idx_s;
  logic [NUM_LANES-1:0]        gnt_onehot_s;
  logic [NUM_LANES-1:0]        pend_kept_s;
  logic [1:0]                  gnt_grade_s;
  logic [COMBO_W-1:0]          combo_nx_s;
  logic [31:0]                 mult_calc_s;
  logic [31:0]                 base_s;
  logic [SUM_W-1:0]            sum_s;
  logic                        busy_s;

  assign hg_s   = hit_grade;
  assign busy_s = (|pending_q) | s1_valid_q;

  // Round-robin grant: first pending lane at or after the pointer.
  always_comb begin
    logic [LW-1:0] lane;
    logic          take;
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    lane        = '0;
    take        = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane        = LW'((int'(ptr_q) + k) % NUM_LANES);
      take        = !gnt_valid_s && pending_q[lane];
      gnt_idx_s   = take ? lane : gnt_idx_s;
      gnt_valid_s = gnt_valid_s | take;
    end
    gnt_onehot_s = gnt_valid_s ? (NUM_LANES'(1) << gnt_idx_s) : '0;
    pend_kept_s  = pending_q & ~gnt_onehot_s;
  end

  // Stage-1 arithmetic for the granted judgement: next combo, multiplier, base points.
  always_comb begin
    gnt_grade_s = grade_q[gnt_idx_s];
    if (gnt_grade_s == 2'b00) begin
      combo_nx_s = '0;
    end else if (combo_q == {COMBO_W{1'b1}}) begin
      combo_nx_s = combo_q;
    end else begin
      combo_nx_s = combo_q + COMBO_W'(1);
    end
    // ceil(c/STEP) rewritten as (c-1)/STEP + 1, valid for c >= 1.
    if (combo_nx_s == '0) begin
      mult_calc_s = 32'd1;
    end else begin
      mult_calc_s = 32'd2 + ((32'(combo_nx_s) - 32'd1) / 32'(COMBO_STEP));
    end
    if (mult_calc_s > 32'(MULT_MAX)) begin
      mult_calc_s = 32'(MULT_MAX);
    end else begin
      mult_calc_s = mult_calc_s;
    end
    case (gnt_grade_s)
      2'b00:   base_s = 32'd0;
      2'b11:   base_s = 32'(PTS_PERFECT);
      default: base_s = 32'(PTS_GOOD);
    endcase
  end

  // Next-state logic: capture, pipeline stages, FSM and game-start clearing.
  always_comb begin
    state_d     = state_q;
    pending_d   = pend_kept_s;
    grade_d     = grade_q;
    ptr_d       = ptr_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    mult_d      = mult_q;
    s1_valid_d  = 1'b0;
    prod_d      = prod_q;
    score_d     = score_q;
    sat_d       = sat_q;
    overrun_d   = overrun_q;
    sum_s       = SUM_W'(score_q) + SUM_W'(prod_q);

    // Stage 1: consume the granted slot.
    if (gnt_valid_s) begin
      ptr_d       = (gnt_idx_s == LW'(NUM_LANES - 1)) ? '0 : gnt_idx_s + LW'(1);
      combo_d     = combo_nx_s;
      max_combo_d = (combo_nx_s > max_combo_q) ? combo_nx_s : max_combo_q;
      mult_d      = 5'(mult_calc_s);
      prod_d      = PROD_W'(base_s * mult_calc_s);
      s1_valid_d  = 1'b1;
    end else begin
      s1_valid_d  = 1'b0;
    end

    // Stage 2: saturating accumulate.
    if (s1_valid_q) begin
      if (sum_s > SUM_W'({SCORE_W{1'b1}})) begin
        score_d = {SCORE_W{1'b1}};
        sat_d   = 1'b1;
      end else begin
        score_d = SCORE_W'(sum_s);
      end
    end else begin
      score_d = score_q;
    end

    // Capture: a slot freed by this edge's grant may take a new hit.
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((state_q == S_PLAY) && hit_valid[i]) begin
        if (pend_kept_s[i]) begin
          overrun_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          grade_d[i]   = hg_s[i];
        end
      end else begin
        pending_d[i] = pend_kept_s[i];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_PLAY;
          score_d     = '0;
          combo_d     = '0;
          max_combo_d = '0;
          mult_d      = 5'd0;
          sat_d       = 1'b0;
          overrun_d   = 1'b0;
          ptr_d       = '0;
        end else begin
          state_d     = state_q;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_DRAIN: begin
        if (!busy_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      grade_q     <= '0;
      ptr_q       <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      mult_q      <= 5'd0;
      s1_valid_q  <= 1'b0;
      prod_q      <= '0;
      score_q     <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      grade_q     <= grade_d;
      ptr_q       <= ptr_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      mult_q      <= mult_d;
      s1_valid_q  <= s1_valid_d;
      prod_q      <= prod_d;
      score_q     <= score_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;
  assign multiplier = mult_q;
  assign state      = state_q;
  assign busy       = busy_s;
  assign saturated  = sat_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_score_combo_engine.sv
// Testbench for score_combo_engine: directed game scenarios followed by
// random play, every cycle compared against a behavioural game model.
// A second instance with a 12-bit score exercises saturation.
module tb_score_combo_engine;

  localparam int NL     = 4;
  localparam int CMAX   = 255;
  localparam int SMAX16 = 65535;
  localparam int SMAX12 = 4095;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [3:0]  hit_valid;
  logic [7:0]  hit_grade;

  logic [15:0] score;
  logic [7:0]  combo, max_combo;
  logic [4:0]  multiplier;
  logic [1:0]  state;
  logic        busy, saturated, overrun;

  logic [11:0] score12;
  logic [7:0]  combo12, max_combo12;
  logic [4:0]  multiplier12;
  logic [1:0]  state12;
  logic        busy12, saturated12, overrun12;

  int n_tests = 0;
  int n_fail  = 0;

  score_combo_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .hit_valid(hit_valid), .hit_grade(hit_grade),
    .score(score), .combo(combo), .max_combo(max_combo), .multiplier(multiplier),
    .state(state), .busy(busy), .saturated(saturated), .overrun(overrun)
  );

  score_combo_engine #(.SCORE_W(12)) dut12 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .hit_valid(hit_valid), .hit_grade(hit_grade),
    .score(score12), .combo(combo12), .max_combo(max_combo12), .multiplier(multiplier12),
    .state(state12), .busy(busy12), .saturated(saturated12), .overrun(overrun12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural game model ----------------
  int m_state, m_ptr, m_combo, m_maxc, m_mult, m_prod, m_ovr;
  int m_score16, m_score12, m_sat16, m_sat12;
  bit m_s1v;
  bit m_pend [NL];
  int m_grade[NL];

  function automatic void model_reset();
    m_state = 0; m_ptr = 0; m_combo = 0; m_maxc = 0; m_mult = 0; m_prod = 0;
    m_ovr = 0; m_score16 = 0; m_score12 = 0; m_sat16 = 0; m_sat12 = 0; m_s1v = 0;
    for (int i = 0; i < NL; i++) begin m_pend[i] = 0; m_grade[i] = 0; end
  endfunction

  function automatic int model_busy();
    int b = int'(m_s1v);
    for (int i = 0; i < NL; i++) b = b | int'(m_pend[i]);
    return b;
  endfunction

  // One clock edge of the game rules, using the inputs currently applied.
  function automatic void model_step();
    int old_busy = model_busy();
    int gl = -1;
    int g, base, s;
    bit new_s1v = 0;
    if (m_s1v) begin
      s = m_score16 + m_prod;
      if (s > SMAX16) begin m_score16 = SMAX16; m_sat16 = 1; end else m_score16 = s;
      s = m_score12 + m_prod;
      if (s > SMAX12) begin m_score12 = SMAX12; m_sat12 = 1; end else m_score12 = s;
    end
    for (int k = 0; k < NL; k++)
      if (gl < 0 && m_pend[(m_ptr + k) % NL]) gl = (m_ptr + k) % NL;
    if (gl >= 0) begin
      g = m_grade[gl];
      m_pend[gl] = 0;
      m_ptr = (gl + 1) % NL;
      m_combo = (g == 0) ? 0 : ((m_combo + 1 > CMAX) ? CMAX : m_combo + 1);
      if (m_combo > m_maxc) m_maxc = m_combo;
      if (m_combo == 0) m_mult = 1;
      else begin
        m_mult = 1 + (m_combo + 15) / 16;
        if (m_mult > 17) m_mult = 17;
      end
      base = (g == 0) ? 0 : ((g == 3) ? 256 : 32);
      m_prod = base * m_mult;
      new_s1v = 1;
    end
    m_s1v = new_s1v;
    if (m_state == 1)
      for (int i = 0; i < NL; i++)
        if (hit_valid[i]) begin
          if (m_pend[i]) m_ovr = 1;
          else begin m_pend[i] = 1; m_grade[i] = int'(hit_grade[2*i +: 2]); end
        end
    case (m_state)
      0, 3: if (start) begin
        m_state = 1; m_score16 = 0; m_score12 = 0; m_combo = 0; m_maxc = 0;
        m_mult = 0; m_sat16 = 0; m_sat12 = 0; m_ovr = 0; m_ptr = 0;
      end
      1: if (stop) m_state = 2;
      2: if (old_busy == 0) m_state = 3;
      default: m_state = 0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("state",      state,      m_state);
    check_val("score",      score,      m_score16);
    check_val("combo",      combo,      m_combo);
    check_val("max_combo",  max_combo,  m_maxc);
    check_val("multiplier", multiplier, m_mult);
    check_val("busy",       busy,       model_busy());
    check_val("saturated",  saturated,  m_sat16);
    check_val("overrun",    overrun,    m_ovr);
    check_val("score12",    score12,    m_score12);
    check_val("sat12",      saturated12, m_sat12);
    check_val("state12",    state12,    m_state);
    check_val("combo12",    combo12,    m_combo);
    check_val("maxc12",     max_combo12, m_maxc);
    check_val("mult12",     multiplier12, m_mult);
    check_val("busy12",     busy12,     model_busy());
    check_val("ovr12",      overrun12,  m_ovr);
  endtask

  task automatic cycle(input logic st, input logic sp, input logic [3:0] hv, input logic [7:0] hg);
    start = st; stop = sp; hit_valid = hv; hit_grade = hg;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    start = 1'b0; stop = 1'b0; hit_valid = 4'd0; hit_grade = 8'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Finish any running game and start a fresh one; drain is bounded.
  task automatic new_game();
    if (m_state == 1) cycle(1'b0, 1'b1, 4'd0, 8'd0);
    for (int i = 0; i < 40 && m_state == 2; i++) idle(1);
    if (m_state == 2) check_val("drain_timeout", state, 3);
    cycle(1'b1, 1'b0, 4'd0, 8'd0);
    check_val("game_started", state, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; hit_valid = 4'd0; hit_grade = 8'd0;
    model_reset();
    #1;
    do_reset();

    // T1: hits without a game are ignored
    cycle(1'b0, 1'b0, 4'b1111, 8'hFF);
    idle(3);
    check_val("t1_score", score, 0);
    check_val("t1_state", state, 0);

    // T2: single perfect
    new_game();
    cycle(1'b0, 1'b0, 4'b0001, 8'b0000_0011);
    idle(1);
    check_val("t2_combo", combo, 1);
    check_val("t2_mult", multiplier, 2);
    idle(1);
    check_val("t2_score", score, 512);

    // T3: 17 goods on lane 1
    new_game();
    for (int n = 0; n < 16; n++) begin
      cycle(1'b0, 1'b0, 4'b0010, 8'b0000_0100);
      idle(1);
    end
    idle(1);
    check_val("t3_score16", score, 1024);
    cycle(1'b0, 1'b0, 4'b0010, 8'b0000_1000);
    idle(1);
    check_val("t3_combo17", combo, 17);
    check_val("t3_mult17", multiplier, 3);
    idle(1);
    check_val("t3_score17", score, 1120);

    // T4: all four lanes at once
    new_game();
    cycle(1'b0, 1'b0, 4'b1111, 8'b11_00_01_11);
    idle(4);
    check_val("t4_busy", busy, 1);
    idle(1);
    check_val("t4_score", score, 1088);
    check_val("t4_combo", combo, 1);
    check_val("t4_maxc", max_combo, 2);
    check_val("t4_idle", busy, 0);

    // T5: 12-bit saturation, then overrun rules
    new_game();
    for (int n = 0; n < 7; n++) begin
      cycle(1'b0, 1'b0, 4'b0001, 8'b0000_0011);
      idle(1);
    end
    idle(1);
    check_val("t5_score7", score12, 3584);
    cycle(1'b0, 1'b0, 4'b0001, 8'b0000_0011);
    idle(2);
    check_val("t5_clamp", score12, 4095);
    check_val("t5_sat", saturated12, 1);
    check_val("t5_nosat16", saturated, 0);
    cycle(1'b0, 1'b0, 4'b0110, 8'b00_01_11_00);
    cycle(1'b0, 1'b0, 4'b0010, 8'b00_00_01_00);
    check_val("t5_grant_recapture", overrun, 0);
    cycle(1'b0, 1'b0, 4'b0010, 8'b00_00_11_00);
    check_val("t5_overrun", overrun, 1);
    idle(4);

    // T6: stop with three lanes pending
    new_game();
    cycle(1'b0, 1'b0, 4'b1110, 8'b11_01_10_00);
    cycle(1'b0, 1'b1, 4'd0, 8'd0);
    check_val("t6_drain", state, 2);
    for (int i = 0; i < 20 && m_state == 2; i++) idle(1);
    check_val("t6_done", state, 3);
    cycle(1'b0, 1'b0, 4'b1111, 8'hFF);
    idle(2);
    check_val("t6_ignored", busy, 0);
    cycle(1'b1, 1'b0, 4'd0, 8'd0);
    check_val("t6_restart", state, 1);
    check_val("t6_cleared", score, 0);

    // Random play against the model
    for (int c = 0; c < 3000; c++) begin
      logic       st, sp;
      logic [3:0] hv;
      logic [7:0] hg;
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
      end else begin
        st = ($urandom_range(0, 99) < 4);
        sp = ($urandom_range(0, 99) < 2);
        hv = 4'($urandom) & 4'($urandom);
        hg = 8'($urandom);
        cycle(st, sp, hv, hg);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
